// File: rtl/memory_round_ctrl_pkg.sv
// memory_round_ctrl_pkg: controller states, datapath state codes, move bit indices
package memory_round_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_FIND, REVEAL, ARM, PLAY, OVER, RESET_DP} state_t;
  // datapath state vector is {qi, qg, qfo, qp, ql}; anything not exactly one of these is no match
  localparam logic [4:0] DP_I  = 5'b10000;
  localparam logic [4:0] DP_G  = 5'b01000;
  localparam logic [4:0] DP_FO = 5'b00100;
  localparam logic [4:0] DP_P  = 5'b00010;
  localparam logic [4:0] DP_L  = 5'b00001;
  localparam int MV_SEL = 4;
  localparam int MV_U   = 3;
  localparam int MV_D   = 2;
  localparam int MV_L   = 1;
  localparam int MV_R   = 0;
  function automatic logic [4:0] prio_grant(input logic [4:0] req);
    return req[MV_SEL] ? 5'b10000 : req[MV_U] ? 5'b01000 : req[MV_D] ? 5'b00100 :
           req[MV_L] ? 5'b00010 : {4'b0000, req[MV_R]};
  endfunction
endpackage

// File: rtl/memory_round_ctrl_if.sv
// memory_round_ctrl_if: board buttons/switches and datapath handshake bundle
interface memory_round_ctrl_if;
  logic       tick, btn_start, btn_r, btn_l, btn_u, btn_d, btn_sel;
  logic [3:0] seed_sw, inc_sw;
  logic       dp_qi, dp_qg, dp_qfo, dp_qp, dp_ql;
  logic       start, right, left, up, down, select, reveal, fault;
  logic [3:0] ss_out, inc_out, round;
  modport master (
    output tick, btn_start, btn_r, btn_l, btn_u, btn_d, btn_sel, seed_sw, inc_sw,
           dp_qi, dp_qg, dp_qfo, dp_qp, dp_ql,
    input  start, right, left, up, down, select, reveal, fault, ss_out, inc_out, round
  );
  modport slave (
    input  tick, btn_start, btn_r, btn_l, btn_u, btn_d, btn_sel, seed_sw, inc_sw,
           dp_qi, dp_qg, dp_qfo, dp_qp, dp_ql,
    output start, right, left, up, down, select, reveal, fault, ss_out, inc_out, round
  );
endinterface

// File: rtl/memory_round_ctrl_move_arbiter.sv
// move_arbiter: pending move register with fixed-priority one-hot grant
module move_arbiter
  import memory_round_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [4:0] btn,
  output logic [4:0] grant
);
  logic [4:0] pending_q, pending_d;
  // grant comes straight off the register, so a lone press pulses one cycle later
  assign grant = prio_grant(pending_q);
  // a press landing on its own grant cycle re-enters pending and is granted again
  always_comb pending_d = (en && !clr) ? ((pending_q & ~grant) | btn) : '0;
  // pending register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending_q <= '0;
    else pending_q <= pending_d;
endmodule

// File: rtl/memory_round_ctrl.sv
// memory_round_ctrl: round sequencer between board buttons and the memory-game datapath
module memory_round_ctrl
  import memory_round_ctrl_pkg::*;
#(
  parameter int REVEAL_TICKS = 8,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 8
) (
  input logic clk,
  input logic rst_n,
  memory_round_ctrl_if.slave bus
);
  localparam int RT = (REVEAL_TICKS == 0) ? 1 : REVEAL_TICKS;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d, tcnt_q, tcnt_d;
  logic [3:0]       ss_q, ss_d, inc_q, inc_d, round_q, round_d;
  logic             fault_q, fault_d, timed;
  logic [4:0]       dp, grant;
  assign dp    = {bus.dp_qi, bus.dp_qg, bus.dp_qfo, bus.dp_qp, bus.dp_ql};
  assign timed = state_q inside {LAUNCH, WAIT_FIND, ARM, RESET_DP};
  move_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == PLAY),
    .clr   (dp == DP_G || dp == DP_L),
    .btn   ({bus.btn_sel, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r}),
    .grant (grant)
  );
  assign bus.start   = state_q inside {LAUNCH, ARM, RESET_DP};
  assign bus.reveal  = (state_q == REVEAL && rcnt_q != '0) || state_q == OVER;
  assign bus.select  = grant[MV_SEL];
  assign bus.up      = grant[MV_U];
  assign bus.down    = grant[MV_D];
  assign bus.left    = grant[MV_L];
  assign bus.right   = grant[MV_R];
  assign bus.ss_out  = ss_q;
  assign bus.inc_out = inc_q;
  assign bus.round   = round_q;
  assign bus.fault   = fault_q;
  // next state, counters and latched values; timed states fall back to IDLE with Fault
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = '0;
    ss_d    = ss_q;
    inc_d   = inc_q;
    round_d = round_q;
    fault_d = fault_q;
    case (state_q)
      IDLE:      if (bus.btn_start) begin
                   state_d = LAUNCH;
                   ss_d    = bus.seed_sw;
                   inc_d   = bus.inc_sw;
                   round_d = '0;
                   fault_d = 1'b0;
                 end
      LAUNCH:    if (dp == DP_G || dp == DP_FO) state_d = WAIT_FIND;
      WAIT_FIND: if (dp == DP_FO) begin
                   state_d = REVEAL;
                   rcnt_d  = CNT_W'(RT);
                 end
      REVEAL:    if (rcnt_q == '0) state_d = ARM;
                 else if (bus.tick) rcnt_d = rcnt_q - CNT_W'(1);
      ARM:       if (dp == DP_P) state_d = PLAY;
      PLAY:      if (dp == DP_G) begin
                   state_d = WAIT_FIND;
                   round_d = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;
                 end else if (dp == DP_L) state_d = OVER;
      OVER:      if (bus.btn_start) state_d = RESET_DP;
      RESET_DP:  if (dp == DP_I) begin
                   state_d = IDLE;
                   round_d = '0;
                 end
    endcase
    if (timed && state_d == state_q) begin
      if (tcnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = IDLE;
        fault_d = 1'b1;
      end else tcnt_d = tcnt_q + CNT_W'(1);
    end
  end
  // controller registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      ss_q    <= '0;
      inc_q   <= '0;
      round_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      ss_q    <= ss_d;
      inc_q   <= inc_d;
      round_q <= round_d;
      fault_q <= fault_d;
    end
endmodule

// File: tb/tb_memory_round_ctrl.sv
// tb_memory_round_ctrl: directed rounds with a move-pulse scoreboard
module tb_memory_round_ctrl;
  import memory_round_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] dp = DP_I;
  int pass_cnt = 0, total = 0;
  logic [4:0] exp_q[$];
  memory_round_ctrl_if bus();
  memory_round_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign {bus.dp_qi, bus.dp_qg, bus.dp_qfo, bus.dp_qp, bus.dp_ql} = dp;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_play_from_wait();
    dp = DP_FO;
    cyc(1);
    chk("reveal_reentry", bus.reveal, 1);
    bus.tick = 1'b1;
    cyc(8);
    bus.tick = 1'b0;
    chk("reveal_done", bus.reveal, 0);
    dp = DP_P;
    cyc(2);
    chk("play_start_low", bus.start, 0);
  endtask

  always @(negedge clk) begin
    logic [4:0] mv, e;
    mv = {bus.select, bus.up, bus.down, bus.left, bus.right};
    if (mv != 5'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL move_unexpected got %b expected none", mv);
      end else begin
        e = exp_q.pop_front();
        chk("move_pulse", {27'b0, mv}, {27'b0, e});
      end
    end
  end

  initial begin
    int n;
    {bus.tick, bus.btn_start, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d, bus.btn_sel} = '0;
    bus.seed_sw = 4'd0;
    bus.inc_sw  = 4'd0;
    cyc(2);
    chk("rst_start", bus.start, 0);
    chk("rst_reveal", bus.reveal, 0);
    chk("rst_round", bus.round, 0);
    chk("rst_fault", bus.fault, 0);
    rst_n = 1'b1;
    cyc(1);
    bus.seed_sw = 4'd5;
    bus.inc_sw  = 4'd3;
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    chk("launch_start", bus.start, 1);
    chk("ss_out", bus.ss_out, 5);
    chk("inc_out", bus.inc_out, 3);
    bus.btn_r = 1'b1;
    dp = DP_G;
    cyc(1);
    bus.btn_r = 1'b0;
    chk("wait_start_low", bus.start, 0);
    dp = DP_FO;
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("reveal_hold", bus.reveal, 1);
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      cyc(1);
    end
    chk("reveal_8_ticks", bus.reveal, 0);
    chk("arm_start", bus.start, 1);
    cyc(3);
    chk("arm_start_held", bus.start, 1);
    dp = DP_P;
    cyc(1);
    chk("play_start_low", bus.start, 0);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b00001);
    {bus.btn_r, bus.btn_u, bus.btn_sel} = 3'b111;
    cyc(1);
    {bus.btn_r, bus.btn_u, bus.btn_sel} = 3'b000;
    cyc(4);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b10000);
    bus.btn_sel = 1'b1;
    cyc(2);
    bus.btn_sel = 1'b0;
    cyc(3);
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b00010);
    {bus.btn_d, bus.btn_l} = 2'b11;
    cyc(1);
    {bus.btn_d, bus.btn_l} = 2'b00;
    cyc(4);
    exp_q.push_back(5'b00001);
    bus.btn_r = 1'b1;
    cyc(1);
    bus.btn_r = 1'b0;
    bus.btn_u = 1'b1;
    dp = DP_G;
    cyc(1);
    bus.btn_u = 1'b0;
    chk("round_1", bus.round, 1);
    for (int i = 0; i < 15; i++) begin
      to_play_from_wait();
      dp = DP_G;
      cyc(1);
      chk("round_count", bus.round, (i + 2 > 15) ? 15 : i + 2);
    end
    to_play_from_wait();
    dp = DP_L;
    cyc(1);
    chk("over_reveal", bus.reveal, 1);
    chk("over_start", bus.start, 0);
    bus.btn_r = 1'b1;
    cyc(1);
    bus.btn_r = 1'b0;
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    chk("resetdp_start", bus.start, 1);
    cyc(5);
    chk("resetdp_start_held", bus.start, 1);
    dp = DP_I;
    cyc(1);
    chk("idle_start", bus.start, 0);
    chk("idle_reveal", bus.reveal, 0);
    chk("idle_round", bus.round, 0);
    chk("idle_fault", bus.fault, 0);
    chk("idle_ss", bus.ss_out, 5);
    chk("idle_inc", bus.inc_out, 3);
    bus.seed_sw = 4'd9;
    bus.inc_sw  = 4'd2;
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    n = 0;
    while (bus.start && n < 200) begin
      n++;
      cyc(1);
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_fault", bus.fault, 1);
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    chk("fault_cleared", bus.fault, 0);
    chk("ss_relatch", bus.ss_out, 9);
    dp = DP_FO;
    cyc(2);
    chk("reveal_before_rst", bus.reveal, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_reveal", bus.reveal, 0);
    chk("async_rst_start", bus.start, 0);
    chk("async_rst_ss", bus.ss_out, 0);
    chk("async_rst_inc", bus.inc_out, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
